// File: rtl/q2_counter.sv
// q2_counter: N-bit free-running sequence generator (binary, Gray, Johnson, one-hot ring, LFSR).
// Define Q2_COUNTER_LFSR_EN to build MODE 4 as an LFSR; without it MODE 4 counts in binary.
`timescale 1ns/1ps
module q2_counter #(
  parameter int N    = 8,
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
  output logic [N-1:0] q
);

`ifdef Q2_COUNTER_LFSR_EN
  localparam int EFF_MODE = (MODE >= 0 && MODE <= 4) ? MODE : 0;

  // Maximal-length Fibonacci taps as a bit mask over q (bit n of the table -> q[n-1]).
  function automatic logic [15:0] lfsrTaps(input int width);
    case (width)
      2:       lfsrTaps = 16'h0003;
      3:       lfsrTaps = 16'h0006;
      4:       lfsrTaps = 16'h000C;
      5:       lfsrTaps = 16'h0014;
      6:       lfsrTaps = 16'h0030;
      7:       lfsrTaps = 16'h0060;
      8:       lfsrTaps = 16'h00B8;
      9:       lfsrTaps = 16'h0110;
      10:      lfsrTaps = 16'h0240;
      11:      lfsrTaps = 16'h0500;
      12:      lfsrTaps = 16'h0829;
      13:      lfsrTaps = 16'h100D;
      14:      lfsrTaps = 16'h2015;
      15:      lfsrTaps = 16'h6000;
      default: lfsrTaps = 16'hD008;
    endcase
  endfunction

  localparam logic [15:0] TAPS_ALL = lfsrTaps(N);
`else
  localparam int EFF_MODE = (MODE >= 0 && MODE <= 3) ? MODE : 0;
`endif

  localparam logic [N-1:0] RESET_Q = (EFF_MODE == 3 || EFF_MODE == 4) ? N'(1) : N'(0);

  logic [N-1:0] r_q;
  logic [N-1:0] r_bin;
  logic [N-1:0] w_binNext;
  logic [N-1:0] w_qNext;
  logic [N-1:0] w_qPlus;
  logic [N-1:0] w_qInvPlus;
  logic [N-1:0] w_qMinus;

  // Illegal Johnson / ring / LFSR states fall back to a known state on the next edge.
  always_comb begin
    w_binNext  = r_bin + 1'b1;
    w_qPlus    = r_q + 1'b1;
    w_qInvPlus = ~r_q + 1'b1;
    w_qMinus   = r_q - 1'b1;
    w_qNext    = w_qPlus;
    case (EFF_MODE)
      1: w_qNext = w_binNext ^ (w_binNext >> 1);
      2: begin
        if (((r_q & w_qPlus) == '0) || ((~r_q & w_qInvPlus) == '0))
          w_qNext = {r_q[N-2:0], ~r_q[N-1]};
        else
          w_qNext = '0;
      end
      3: begin
        if ((r_q != '0) && ((r_q & w_qMinus) == '0))
          w_qNext = {r_q[N-2:0], r_q[N-1]};
        else
          w_qNext = N'(1);
      end
`ifdef Q2_COUNTER_LFSR_EN
      4: begin
        if (r_q == '0)
          w_qNext = N'(1);
        else
          w_qNext = {r_q[N-2:0], ^(r_q & TAPS_ALL[N-1:0])};
      end
`endif
      default: w_qNext = w_qPlus;
    endcase
  end

  // The Gray binary count and q share one edge so q always encodes the current count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= RESET_Q;
      r_bin <= '0;
    end else begin
      r_q   <= w_qNext;
      r_bin <= w_binNext;
    end
  end

  assign q = r_q;

endmodule

// File: tb/tb_q2_counter.sv
// tb_q2_counter: directed checks of every q2_counter mode, self-correction and async reset.
`timescale 1ns/1ps
module tb_q2_counter;

  logic       clk;
  logic       rst;
  logic [7:0] q0;
  logic [7:0] q1;
  logic [3:0] q2;
  logic [3:0] q3;
  logic [7:0] q4;
  logic [3:0] q7;

  int totalChecks = 0;
  int badChecks   = 0;
  int firstRepeat = 0;

  q2_counter #(.N(8), .MODE(0)) dut0 (.clk(clk), .rst(rst), .q(q0));
  q2_counter #(.N(8), .MODE(1)) dut1 (.clk(clk), .rst(rst), .q(q1));
  q2_counter #(.N(4), .MODE(2)) dut2 (.clk(clk), .rst(rst), .q(q2));
  q2_counter #(.N(4), .MODE(3)) dut3 (.clk(clk), .rst(rst), .q(q3));
  q2_counter #(.N(8), .MODE(4)) dut4 (.clk(clk), .rst(rst), .q(q4));
  q2_counter #(.N(4), .MODE(7)) dut7 (.clk(clk), .rst(rst), .q(q7));

  initial begin
    clk = 1'b0;
    forever #2 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Outputs are sampled 1 ns after the rising edge.
  task automatic applyStimulus(input int edges);
    repeat (edges) @(posedge clk);
    #1;
  endtask

  logic [7:0] grayExp [5]   = '{8'd1, 8'd3, 8'd2, 8'd6, 8'd7};
  logic [3:0] johnExp [8]   = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [3:0] ringExp [4]   = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    rst = 1'b1;
    #0.5;
    checkOutput("reset_bin",  16'(q0), 16'h0000);
    checkOutput("reset_gray", 16'(q1), 16'h0000);
    checkOutput("reset_john", 16'(q2), 16'h0000);
    checkOutput("reset_ring", 16'(q3), 16'h0001);
`ifdef Q2_COUNTER_LFSR_EN
    checkOutput("reset_lfsr", 16'(q4), 16'h0001);
`else
    checkOutput("reset_mode4", 16'(q4), 16'h0000);
`endif
    checkOutput("reset_mode7", 16'(q7), 16'h0000);
    #0.5;
    rst = 1'b0;
    #0.5;
    checkOutput("bin_before_edge", 16'(q0), 16'h0000);

    for (int e = 1; e <= 293; e++) begin
      applyStimulus(1);
      if (e == 1) checkOutput("bin_edge1", 16'(q0), 16'h0001);
      if (e == 2) checkOutput("bin_edge2", 16'(q0), 16'h0002);
      if (e <= 5) checkOutput($sformatf("gray_edge%0d", e), 16'(q1), 16'(grayExp[e-1]));
      if (e <= 8) checkOutput($sformatf("john_edge%0d", e), 16'(q2), 16'(johnExp[e-1]));
      if (e <= 4) checkOutput($sformatf("ring_edge%0d", e), 16'(q3), 16'(ringExp[e-1]));
`ifdef Q2_COUNTER_LFSR_EN
      if (e == 1) checkOutput("lfsr_edge1", 16'(q4), 16'h0002);
      if (e == 2) checkOutput("lfsr_edge2", 16'(q4), 16'h0004);
      if (q4 == 8'h01 && firstRepeat == 0) firstRepeat = e;
`else
      if (e == 1) checkOutput("mode4_edge1", 16'(q4), 16'h0001);
      if (e == 2) checkOutput("mode4_edge2", 16'(q4), 16'h0002);
      if (e == 256) checkOutput("mode4_wrap", 16'(q4), 16'h0000);
`endif
      if (e == 8) begin
        // Corrupt the ring and Johnson registers between edges to exercise recovery.
        force dut3.r_q = 4'b0101;
        force dut2.r_q = 4'b0101;
        #1;
        release dut3.r_q;
        release dut2.r_q;
      end
      if (e == 9) begin
        checkOutput("ring_recover", 16'(q3), 16'h0001);
        checkOutput("john_recover", 16'(q2), 16'h0000);
        checkOutput("mode7_as_bin", 16'(q7), 16'h0009);
      end
      if (e == 255) checkOutput("bin_edge255", 16'(q0), 16'h00FF);
      if (e == 256) checkOutput("bin_wrap", 16'(q0), 16'h0000);
    end

`ifdef Q2_COUNTER_LFSR_EN
    checkOutput("lfsr_period", 16'(firstRepeat), 16'd255);
`endif

    checkOutput("bin_at_37", 16'(q0), 16'd37);
    rst = 1'b1;
    #0.5;
    checkOutput("async_reset_bin", 16'(q0), 16'h0000);
    checkOutput("async_reset_ring", 16'(q3), 16'h0001);
    #0.5;
    rst = 1'b0;
    applyStimulus(1);
    checkOutput("bin_after_reset", 16'(q0), 16'h0001);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
